// File: rtl/router_pkg.sv
// Shared constants and address encodings for the 1x3 packet router.
package router_pkg;

  localparam int ADDR_W         = 2;
  localparam int NUM_PORTS      = 3;
  localparam int TIMEOUT_CYCLES = 30;
  localparam int CNT_W          = 5;

  typedef enum logic [ADDR_W-1:0] {
    ADDR_P0      = 2'b00,
    ADDR_P1      = 2'b01,
    ADDR_P2      = 2'b10,
    ADDR_INVALID = 2'b11
  } addr_e;

  // One-hot port select; the invalid address selects nothing.
  function automatic logic [NUM_PORTS-1:0] addr_onehot(input addr_e addr);
    logic [NUM_PORTS-1:0] oh;
    oh = '0;
    case (addr)
      ADDR_P0: oh = 3'b001;
      ADDR_P1: oh = 3'b010;
      ADDR_P2: oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/router_sync_timeout.sv
// Per-port stall watchdog: pulses soft_reset for one cycle after
// TIMEOUT_CYCLES consecutive cycles of valid-but-unread output.
module router_sync_timeout #(
  parameter int TIMEOUT_CYCLES = router_pkg::TIMEOUT_CYCLES,
  parameter int CNT_W          = router_pkg::CNT_W
) (
  input  logic clock,
  input  logic resetn,
  input  logic vld,
  input  logic rd,
  output logic soft_reset
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (!vld || rd) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
      // Wrap to zero so a persistent stall re-fires every TIMEOUT_CYCLES.
      cnt        <= '0;
      soft_reset <= 1'b1;
    end else begin
      cnt        <= cnt + CNT_W'(1);
      soft_reset <= 1'b0;
    end
  end

endmodule

// File: rtl/router_sync.sv
// Router synchronizer glue: address latch, FIFO write steering, full/valid
// reporting and per-port stall soft resets.
module router_sync
  import router_pkg::*;
(
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 detect_add,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 write_enb_reg,
  input  logic                 read_enb_0,
  input  logic                 read_enb_1,
  input  logic                 read_enb_2,
  input  logic                 empty_0,
  input  logic                 empty_1,
  input  logic                 empty_2,
  input  logic                 full_0,
  input  logic                 full_1,
  input  logic                 full_2,
  output logic                 vld_out_0,
  output logic                 vld_out_1,
  output logic                 vld_out_2,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 fifo_full,
  output logic                 soft_reset_0,
  output logic                 soft_reset_1,
  output logic                 soft_reset_2
);

  addr_e addr_q;

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn)          addr_q <= ADDR_P0;
    else if (detect_add) addr_q <= addr_e'(data_in);
  end

  // Decoders use the registered address only, so a header arriving alongside
  // a write still steers that write by the previous packet's address.
  always_comb begin
    write_enb = '0;
    if (write_enb_reg) write_enb = addr_onehot(addr_q);
  end

  always_comb begin
    fifo_full = 1'b0;
    case (addr_q)
      ADDR_P0: fifo_full = full_0;
      ADDR_P1: fifo_full = full_1;
      ADDR_P2: fifo_full = full_2;
      default: fifo_full = 1'b0;
    endcase
  end

  assign vld_out_0 = ~empty_0;
  assign vld_out_1 = ~empty_1;
  assign vld_out_2 = ~empty_2;

  router_sync_timeout u_timeout_0 (
    .clock      (clock),
    .resetn     (resetn),
    .vld        (vld_out_0),
    .rd         (read_enb_0),
    .soft_reset (soft_reset_0)
  );

  router_sync_timeout u_timeout_1 (
    .clock      (clock),
    .resetn     (resetn),
    .vld        (vld_out_1),
    .rd         (read_enb_1),
    .soft_reset (soft_reset_1)
  );

  router_sync_timeout u_timeout_2 (
    .clock      (clock),
    .resetn     (resetn),
    .vld        (vld_out_2),
    .rd         (read_enb_2),
    .soft_reset (soft_reset_2)
  );

endmodule

// File: tb/tb_router_sync.sv
// Directed self-checking bench for router_sync.
module tb_router_sync;

  logic       clock = 1'b0;
  logic       resetn;
  logic       detect_add;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       empty_0, empty_1, empty_2;
  logic       full_0, full_1, full_2;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  router_sync dut (
    .clock         (clock),
    .resetn        (resetn),
    .detect_add    (detect_add),
    .data_in       (data_in),
    .write_enb_reg (write_enb_reg),
    .read_enb_0    (read_enb_0),
    .read_enb_1    (read_enb_1),
    .read_enb_2    (read_enb_2),
    .empty_0       (empty_0),
    .empty_1       (empty_1),
    .empty_2       (empty_2),
    .full_0        (full_0),
    .full_1        (full_1),
    .full_2        (full_2),
    .vld_out_0     (vld_out_0),
    .vld_out_1     (vld_out_1),
    .vld_out_2     (vld_out_2),
    .write_enb     (write_enb),
    .fifo_full     (fifo_full),
    .soft_reset_0  (soft_reset_0),
    .soft_reset_1  (soft_reset_1),
    .soft_reset_2  (soft_reset_2)
  );

  wire [2:0] soft_v = {soft_reset_2, soft_reset_1, soft_reset_0};
  wire [2:0] vld_v  = {vld_out_2, vld_out_1, vld_out_0};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_addr(input logic [1:0] a);
    detect_add = 1'b1;
    data_in    = a;
    tick();
    detect_add = 1'b0;
  endtask

  initial begin
    logic [2:0] exp_soft;
    bit         seen;

    resetn = 1'b1; detect_add = 1'b0; data_in = 2'd0; write_enb_reg = 1'b0;
    {read_enb_2, read_enb_1, read_enb_0} = 3'b000;
    {empty_2, empty_1, empty_0} = 3'b111;
    {full_2, full_1, full_0} = 3'b000;
    #12;
    check("rst_write_enb", 8'(write_enb), 8'h0);
    check("rst_fifo_full", 8'(fifo_full), 8'h0);
    check("rst_vld_out", 8'(vld_v), 8'h0);
    check("rst_soft_reset", 8'(soft_v), 8'h0);
    resetn = 1'b0;
    tick();

    // Address latch and write steering
    load_addr(2'd2);
    write_enb_reg = 1'b1; #1;
    check("we_addr2", 8'(write_enb), 8'h4);
    // Header and write together: decode must use the old address
    detect_add = 1'b1; data_in = 2'd0; #1;
    check("we_old_addr", 8'(write_enb), 8'h4);
    tick();
    detect_add = 1'b0; #1;
    check("we_addr0", 8'(write_enb), 8'h1);
    load_addr(2'd1); #1;
    check("we_addr1", 8'(write_enb), 8'h2);
    load_addr(2'd3); #1;
    check("we_addr3", 8'(write_enb), 8'h0);
    load_addr(2'd1);
    write_enb_reg = 1'b0; #1;
    check("we_disabled", 8'(write_enb), 8'h0);

    // fifo_full mux
    full_1 = 1'b1; #1;
    check("full_addr1", 8'(fifo_full), 8'h1);
    full_1 = 1'b0;
    load_addr(2'd2);
    full_2 = 1'b1; #1;
    check("full_addr2_set", 8'(fifo_full), 8'h1);
    full_2 = 1'b0; #1;
    check("full_addr2_clr", 8'(fifo_full), 8'h0);
    load_addr(2'd3);
    {full_2, full_1, full_0} = 3'b111; #1;
    check("full_addr3", 8'(fifo_full), 8'h0);
    {full_2, full_1, full_0} = 3'b000;

    // Port 2 continuously read: never times out
    empty_2 = 1'b0; read_enb_2 = 1'b1; #1;
    check("vld_out_2", 8'(vld_v), 8'h4);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (soft_reset_2) seen = 1'b1;
    end
    check("read_no_timeout", 8'(seen), 8'h0);

    // Ports 0 and 1 stalled together: pulses on edges 30 and 60 only
    empty_0 = 1'b0; empty_1 = 1'b0;
    for (int e = 1; e <= 61; e++) begin
      tick();
      exp_soft = (e == 30 || e == 60) ? 3'b011 : 3'b000;
      check($sformatf("stall_e%0d", e), 8'(soft_v), 8'(exp_soft));
    end
    empty_1 = 1'b1;

    // Read on edge 15 restarts port 0 count: next pulse on edge 45
    empty_0 = 1'b1; tick();
    empty_0 = 1'b0;
    for (int e = 1; e <= 46; e++) begin
      read_enb_0 = (e == 15);
      tick();
      exp_soft = (e == 45) ? 3'b001 : 3'b000;
      check($sformatf("restart_e%0d", e), 8'(soft_v), 8'(exp_soft));
    end
    read_enb_0 = 1'b0;

    // Reset mid-count (cnt=20), then 30 new stalled edges
    empty_0 = 1'b1; tick();
    empty_0 = 1'b0;
    repeat (20) tick();
    #2 resetn = 1'b1; write_enb_reg = 1'b1; #1;
    check("midrst_soft", 8'(soft_v), 8'h0);
    check("midrst_we", 8'(write_enb), 8'h1);
    tick();
    #2 resetn = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      tick();
      exp_soft = (e == 30) ? 3'b001 : 3'b000;
      check($sformatf("post_rst_e%0d", e), 8'(soft_v), 8'(exp_soft));
    end
    // Reset while the pulse is high kills it at once
    #2 resetn = 1'b1; #1;
    check("rst_kills_pulse", 8'(soft_v), 8'h0);
    check("post_rst_we", 8'(write_enb), 8'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
